// File: rtl/reg_bank_arbiter_pkg.sv
// reg_bank_arbiter_pkg: shared types and constants for the register-bank arbiter
//   arb_state_t     arbiter FSM states
//   REG_RD_LATENCY  register_bank read latency, default for RD_LATENCY
package reg_bank_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RD_WAIT,
        RD_RESP
    } arb_state_t;

    localparam int REG_RD_LATENCY = 1;

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// reg_bank_arbiter_if: requester and register_bank signals around the arbiter
//   req/req_we/req_addr/req_wdata  per-port request side, port i in slice i
//   gnt/rvalid/rdata/busy          per-port responses and arbiter status
//   mem_*                          register_bank access port
//   slave modport: arbiter view; master modport: requester/bank view
interface reg_bank_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_write_en;
    logic [DATA_W-1:0]         mem_write_data;
    logic                      mem_read_strobe;
    logic [DATA_W-1:0]         mem_read_data;

    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_read_data,
        output gnt, rvalid, rdata, busy, mem_addr, mem_write_en, mem_write_data, mem_read_strobe
    );

    modport master (
        output req, req_we, req_addr, req_wdata, mem_read_data,
        input  gnt, rvalid, rdata, busy, mem_addr, mem_write_en, mem_write_data, mem_read_strobe
    );

endinterface

// File: rtl/reg_bank_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin winner select with an internal last-winner pointer
//   clk, rst    clock, synchronous active-low reset
//   req_i       per-port request vector
//   advance_i   accept the current winner; pointer moves to it
//   grant_o     one-hot winner, combinational from req_i and the pointer
//   valid_o     some port is requesting
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               valid_o
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0] ptr_q, ptr_d, sel, idx;

    assign valid_o = |req_i;

    // Scan from farthest to nearest after the pointer so the nearest requester wins.
    always_comb begin
        sel = ptr_q;
        idx = ptr_q;
        for (int k = NUM_REQ; k > 0; k--) begin
            idx = PW'((int'(ptr_q) + k) % NUM_REQ);
            sel = req_i[idx] ? idx : sel;
        end
        grant_o = '0;
        grant_o[sel] = valid_o;
        ptr_d = (advance_i && valid_o) ? sel : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) ptr_q <= PW'(NUM_REQ - 1);
        else      ptr_q <= ptr_d;
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin sharing of the single-port register_bank
//   clk, rst  clock, synchronous active-low reset
//   bus       slave view of reg_bank_arbiter_if: per-port req/we/addr/wdata in,
//             gnt/rvalid/rdata/busy out, register_bank mem_* port; all outputs registered
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = REG_RD_LATENCY
) (
    input logic               clk,
    input logic               rst,
    reg_bank_arbiter_if.slave bus
);
    localparam int CW = $clog2(RD_LATENCY + 1);

    arb_state_t          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  win_q, win_d, gnt_q, gnt_d, rvalid_q, rvalid_d;
    logic                we_q, we_d, busy_q, busy_d, wen_q, wen_d, rstb_q, rstb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, sel_addr;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d, sel_wdata;
    logic [NUM_REQ-1:0]  win;
    logic                arb_valid, advance, sel_we;

    assign advance = (state_q == IDLE) && arb_valid;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req_i     (bus.req),
        .advance_i (advance),
        .grant_o   (win),
        .valid_o   (arb_valid)
    );

    // One-hot mux of the winning port's request fields.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_addr  = sel_addr  | (win[i] ? bus.req_addr[i*ADDR_W +: ADDR_W]  : '0);
            sel_wdata = sel_wdata | (win[i] ? bus.req_wdata[i*DATA_W +: DATA_W] : '0);
            sel_we    = sel_we    | (win[i] & bus.req_we[i]);
        end
    end

    // Outputs are computed one state ahead so they are registered and line up with the state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        gnt_d    = '0;
        rvalid_d = '0;
        wen_d    = 1'b0;
        rstb_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = ISSUE;
                    win_d   = win;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    gnt_d   = win;
                    wen_d   = sel_we;
                    rstb_d  = !sel_we;
                end
            end
            ISSUE: begin
                state_d = we_q ? IDLE : RD_WAIT;
                cnt_d   = we_q ? cnt_q : CW'(RD_LATENCY);
            end
            RD_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d  = RD_RESP;
                    rdata_d  = bus.mem_read_data;
                    rvalid_d = win_q;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            win_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            wen_q    <= 1'b0;
            rstb_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            wen_q    <= wen_d;
            rstb_q   <= rstb_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.gnt             = gnt_q;
    assign bus.rvalid          = rvalid_q;
    assign bus.rdata           = rdata_q;
    assign bus.busy            = busy_q;
    assign bus.mem_addr        = addr_q;
    assign bus.mem_write_en    = wen_q;
    assign bus.mem_write_data  = wdata_q;
    assign bus.mem_read_strobe = rstb_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: directed bench for reg_bank_arbiter at RD_LATENCY 1 and 3
module tb_reg_bank_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    reg_bank_arbiter_if #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(8)) i1 ();
    reg_bank_arbiter_if #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(8)) i3 ();

    reg_bank_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(8), .RD_LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (i1.slave)
    );

    reg_bank_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(8), .RD_LATENCY(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (i3.slave)
    );

    // Register bank models: read data is valid only RD_LATENCY cycles after the strobe, else 0.
    logic [7:0] mem1 [256];
    logic [7:0] mem3 [256];
    logic       v1;
    logic [7:0] d1;
    logic [2:0] v3;
    logic [7:0] p3 [3];
    int         strb3 = 0;

    initial mem3[8'h22] = 8'h5C;

    always @(posedge clk) begin
        if (i1.mem_write_en) mem1[i1.mem_addr] <= i1.mem_write_data;
        v1 <= !rst ? 1'b0 : i1.mem_read_strobe;
        d1 <= mem1[i1.mem_addr];
        v3 <= !rst ? 3'b000 : {v3[1:0], i3.mem_read_strobe};
        p3[0] <= mem3[i3.mem_addr];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
        if (rst && i3.mem_read_strobe) strb3 <= strb3 + 1;
    end

    assign i1.mem_read_data = v1 ? d1 : 8'h00;
    assign i3.mem_read_data = v3[2] ? p3[2] : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Protocol monitor on the latency-1 instance.
    logic [1:0] pend1 = 2'b00;
    always @(negedge clk) begin
        if (!rst) pend1 = 2'b00;
        else begin
            chk("gnt_onehot", 32'($onehot0(i1.gnt)), 1);
            chk("wen_rstb_excl", 32'(i1.mem_write_en & i1.mem_read_strobe), 0);
            chk("gnt_rvalid_excl", 32'(|(i1.gnt & i1.rvalid)), 0);
            for (int i = 0; i < 2; i++) begin
                if (i1.rvalid[i]) begin
                    chk("rvalid_has_read", 32'(pend1[i]), 1);
                    pend1[i] = 1'b0;
                end
                if (i1.gnt[i] && i1.mem_read_strobe) begin
                    chk("read_not_pending", 32'(pend1[i]), 0);
                    pend1[i] = 1'b1;
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b0;
        i1.req = '0; i1.req_we = '0; i1.req_addr = '0; i1.req_wdata = '0;
        i3.req = '0; i3.req_we = '0; i3.req_addr = '0; i3.req_wdata = '0;
        tick();
        tick();
        chk("reset_outs", {i1.gnt, i1.rvalid, i1.rdata, i1.busy, i1.mem_addr, i1.mem_write_en,
                           i1.mem_write_data, i1.mem_read_strobe}, 0);
        chk("reset_outs3", {i3.gnt, i3.rvalid, i3.rdata, i3.busy, i3.mem_addr, i3.mem_write_en,
                            i3.mem_write_data, i3.mem_read_strobe}, 0);
        rst = 1'b1;
        tick();

        // Single write from port 0.
        i1.req = 2'b01; i1.req_we = 2'b01; i1.req_addr[7:0] = 8'h10; i1.req_wdata[7:0] = 8'hA5;
        tick();
        chk("wr_gnt", i1.gnt, 2'b01);
        chk("wr_wen", i1.mem_write_en, 1);
        chk("wr_rstb", i1.mem_read_strobe, 0);
        chk("wr_addr", i1.mem_addr, 8'h10);
        chk("wr_data", i1.mem_write_data, 8'hA5);
        chk("wr_rvalid", i1.rvalid, 0);
        chk("wr_busy", i1.busy, 1);
        i1.req = 2'b00;
        tick();
        chk("wr_busy_low", i1.busy, 0);
        chk("wr_wen_low", i1.mem_write_en, 0);
        chk("wr_addr_hold", i1.mem_addr, 8'h10);

        // Read back from port 1, latency 1.
        i1.req = 2'b10; i1.req_we = 2'b00; i1.req_addr[15:8] = 8'h10;
        tick();
        chk("rd_gnt", i1.gnt, 2'b10);
        chk("rd_rstb", i1.mem_read_strobe, 1);
        chk("rd_wen", i1.mem_write_en, 0);
        chk("rd_addr", i1.mem_addr, 8'h10);
        i1.req = 2'b00;
        tick();
        chk("rd_rvalid_early", i1.rvalid, 0);
        chk("rd_busy", i1.busy, 1);
        tick();
        chk("rd_rvalid", i1.rvalid, 2'b10);
        chk("rd_rdata", i1.rdata, 8'hA5);
        tick();
        chk("rd_rvalid_pulse", i1.rvalid, 0);
        chk("rd_rdata_hold", i1.rdata, 8'hA5);
        chk("rd_busy_low", i1.busy, 0);

        // Contention straight after reset: grants alternate 0,1,0,1,0,1.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        i1.req = 2'b11; i1.req_we = 2'b11;
        i1.req_addr = 16'h0201; i1.req_wdata = 16'h2211;
        for (int t = 0; t < 6; t++) begin
            n = 0;
            while (i1.gnt == 2'b00 && n < 8) begin
                tick();
                n++;
            end
            chk("cont_wait", 32'(n < 8), 1);
            chk("cont_gnt", i1.gnt, (t % 2 == 0) ? 2'b01 : 2'b10);
            chk("cont_addr", i1.mem_addr, (t % 2 == 0) ? 8'h01 : 8'h02);
            chk("cont_data", i1.mem_write_data, (t % 2 == 0) ? 8'h11 : 8'h22);
            tick();
        end
        i1.req = 2'b00;
        tick();
        tick();

        // Reset during RD_WAIT discards the read.
        i1.req = 2'b01; i1.req_we = 2'b00; i1.req_addr[7:0] = 8'h10;
        tick();
        chk("mid_gnt", i1.gnt, 2'b01);
        i1.req = 2'b00;
        tick();
        rst = 1'b0;
        tick();
        chk("mid_reset_outs", {i1.gnt, i1.rvalid, i1.rdata, i1.busy, i1.mem_addr, i1.mem_write_en,
                               i1.mem_write_data, i1.mem_read_strobe}, 0);
        rst = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("mid_no_rvalid", i1.rvalid, 0);
        end

        // A read after the reset completes normally.
        i1.req = 2'b10; i1.req_addr[15:8] = 8'h10;
        tick();
        chk("post_gnt", i1.gnt, 2'b10);
        i1.req = 2'b00;
        tick();
        tick();
        chk("post_rvalid", i1.rvalid, 2'b10);
        chk("post_rdata", i1.rdata, 8'hA5);
        tick();
        chk("reads_answered", pend1, 0);

        // Latency-3 instance: rvalid at N+5, one strobe.
        i3.req = 2'b01; i3.req_we = 2'b00; i3.req_addr[7:0] = 8'h22;
        tick();
        chk("l3_gnt", i3.gnt, 2'b01);
        chk("l3_rstb", i3.mem_read_strobe, 1);
        i3.req = 2'b00;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("l3_rvalid_early", i3.rvalid, 0);
        end
        tick();
        chk("l3_rvalid", i3.rvalid, 2'b01);
        chk("l3_rdata", i3.rdata, 8'h5C);
        tick();
        chk("l3_rvalid_pulse", i3.rvalid, 0);
        chk("l3_busy_low", i3.busy, 0);
        chk("l3_strobes", strb3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Shares the single-port register_bank between up to NUM_REQ requesters: cmd_dispatcher on port 0, a hardware status/scrub agent on port 1.
- Each requester presents one read or write at a time; the arbiter picks one round-robin, drives the bank's write_en/read_strobe/addr/write_data, and returns read data with a one-cycle valid pulse.
- Sits between the requesters and register_bank; it replaces the direct cmd_dispatcher-to-register_bank connection.

Parameters:
- NUM_REQ, 2, number of requester ports (2..4).
- ADDR_W, 8, register address width.
- DATA_W, 8, register data width.
- RD_LATENCY, 1, cycles from read_strobe to valid mem_read_data (1..4).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- req  in  NUM_REQ  per-port request, held until that port's gnt.
- req_we  in  NUM_REQ  per-port: 1=write, 0=read; stable while req high.
- req_addr  in  NUM_REQ*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  per-port write data.
- gnt  out  NUM_REQ  one-hot, one-cycle pulse when the port's access is issued.
- rvalid  out  NUM_REQ  one-hot, one-cycle pulse: read data for that port.
- rdata  out  DATA_W  read data; meaningful only while some rvalid bit is high.
- busy  out  1  high whenever the FSM is not in IDLE.
- mem_addr  out  ADDR_W  to register_bank addr.
- mem_write_en  out  1  to register_bank write_en.
- mem_write_data  out  DATA_W  to register_bank write_data.
- mem_read_strobe  out  1  to register_bank read_strobe.
- mem_read_data  in  DATA_W  from register_bank read_data.

Behaviour:
- Reset (rst=0 at a clock edge):
  - All outputs go to 0 and the FSM goes to IDLE.
  - The round-robin pointer goes to NUM_REQ-1, so port 0 wins the first contention.
  - An in-flight read is discarded; no rvalid is issued for it.
- All outputs are registered.
- FSM states: IDLE, ISSUE, RD_WAIT, RD_RESP.
- IDLE:
  - Samples req. If nonzero, it picks a winner W by round-robin: the first requesting port after the pointer, wrapping modulo NUM_REQ.
  - It latches W, we, addr, wdata and moves to ISSUE. The pointer updates to W.
  - If req is zero, it stays in IDLE.
- ISSUE (exactly one cycle):
  - gnt[W]=1. mem_addr and mem_write_data are driven from the latched values.
  - A write asserts mem_write_en=1 and returns to IDLE.
  - A read asserts mem_read_strobe=1, loads the latency counter with RD_LATENCY, and moves to RD_WAIT.
- RD_WAIT:
  - The counter decrements each cycle. In the cycle the counter reaches 1, mem_read_data is captured.
  - The FSM then moves to RD_RESP.
- RD_RESP (exactly one cycle):
  - rvalid[W]=1 and rdata holds the captured data. Next state is IDLE.
- Timing:
  - With a request sampled at cycle N, gnt and the mem strobe appear at N+1.
  - A write completes at N+1; peak throughput is one write per 2 cycles.
  - For a read, rvalid appears at N+2+RD_LATENCY.
- gnt is never asserted for a port whose req was low when IDLE sampled it.
- A requester dropping req before gnt is a protocol violation. The arbiter samples req only in IDLE and ignores changes in other states.
- Simultaneous requests: exactly one gnt per transaction. Under continuous requests from all ports, grants rotate strictly, and no port waits more than NUM_REQ-1 transactions.
- mem_write_en and mem_read_strobe are mutually exclusive and each is high for exactly one cycle per transaction.
- mem_addr and mem_write_data hold their last value outside ISSUE. rdata holds its last value after RD_RESP.
- rvalid and gnt are never high in the same cycle.

Decomposition:
- Add to the shared package alongside cmd_packet_t:
  - arb_state_t enum {IDLE, ISSUE, RD_WAIT, RD_RESP}.
  - Constant REG_RD_LATENCY = 1, used as the RD_LATENCY default at instantiation.
- One sub-module, rr_arbiter:
  - Parameter NUM_REQ.
  - Inputs: clk, rst, req vector, advance strobe.
  - Outputs: one-hot winner and valid. The pointer register lives inside it and updates only on advance.
- The FSM, latches and latency counter stay in reg_bank_arbiter.

Test Plan:
- Reset then single write: port 0 write addr 0x10 data 0xA5, req at cycle N -> gnt[0], mem_write_en=1, mem_addr=0x10, mem_write_data=0xA5 all at N+1; no rvalid; busy low at N+2.
- Read-back with RD_LATENCY=1: port 1 reads 0x10 after the above -> gnt[1] and mem_read_strobe at N+1; rvalid[1] with rdata=0xA5 at N+3; rvalid[0] stays 0.
- Contention: both ports request in the same cycle straight after reset -> port 0 granted first, port 1 next. With both held continuously for 6 transactions -> grant order 0,1,0,1,0,1.
- Latency sweep: RD_LATENCY=3, read of a preloaded register 0x22=0x5C -> rvalid at N+5, rdata=0x5C, exactly one mem_read_strobe.
- Reset mid-read: assert rst=0 in the RD_WAIT cycle -> no rvalid ever, all outputs 0 next cycle. A subsequent read issues and completes normally.
- Protocol checks across all tests: gnt one-hot, at most one of mem_write_en/mem_read_strobe, gnt and rvalid never coincident, every gnt for a read followed by exactly one rvalid to the same port.
